ram_responder: RTL and testbench

- Slave-side responder for the core's data RAM port (`ram_en` / `ram_write_en` / `ram_addr` / `ram_write_data` → `ram_read_data`).
- Holds a word-organised on-chip data memory with byte-lane writes.
- Inserts a programmable number of wait states by raising `stall`, which the top level ORs into the core's `stall` input.
- Sits beside the core in the SoC top, replacing a zero-latency RAM model.

---
 rtl/ram_responder.sv | 176 +++++++++++++++++
 tb/tb_ram_responder.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Purpose : data-RAM slave for the core MEM stage, word memory with byte-lane writes.
// Latency : WAIT_CYCLES+1 cycles per access (combinational read when WAIT_CYCLES == 0).
// Backpr. : raises stall while an access is incomplete; the core freezes until it drops.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   ram_en          access request
//   ram_write_en    byte-lane strobes, 0 = read
//   ram_addr        byte address, bits [1:0] ignored for addressing
//   ram_write_data  lane-aligned store data
//   ram_read_data   unshifted read word
//   stall           access in progress
//   bus_err         (RAM_RESPONDER_ERR_EN only) one-cycle error pulse
//   err_count       (RAM_RESPONDER_ERR_EN only) saturating error count
//
// Optional feature macro: RAM_RESPONDER_ERR_EN
module ram_responder #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ram_en,
   input  logic [3:0]  ram_write_en,
   input  logic [31:0] ram_addr,
   input  logic [31:0] ram_write_data,
   output logic [31:0] ram_read_data,
   output logic        stall
`ifdef RAM_RESPONDER_ERR_EN
   ,
   output logic        bus_err,
   output logic [15:0] err_count
`endif
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

   logic [31:0] r_mem [DEPTH];

   // Decode of the live request.
   logic                  w_hit;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic                  w_err;
   assign w_hit = (ram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
   assign w_idx = ram_addr[ADDR_WIDTH+1:2];
   assign w_err = !w_hit || ((ram_addr[1:0] != 2'b00) && (ram_write_en == 4'hF));

   // Single memory write port, driven by whichever timing mode is built.
   logic                  w_wr_en;
   logic [ADDR_WIDTH-1:0] w_wr_idx;
   logic [3:0]            w_wr_strb;
   logic [31:0]           w_wr_dat;
   logic                  w_err_evt;
   logic                  w_bus_err;

   // Memory is never cleared; a write landing on a reset edge is aborted.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (w_wr_strb[i]) r_mem[w_wr_idx][8*i +: 8] <= w_wr_dat[8*i +: 8];
         end
      end
   end

   generate
      if (WAIT_CYCLES == 0) begin : g_zero_wait
         assign stall         = 1'b0;
         // Combinational read shows the pre-write word during a store.
         assign ram_read_data = (ram_en && w_hit) ? r_mem[w_idx] : 32'h0;
         assign w_wr_en       = ram_en && w_hit;
         assign w_wr_idx      = w_idx;
         assign w_wr_strb     = ram_write_en;
         assign w_wr_dat      = ram_write_data;
         assign w_bus_err     = ram_en && w_err && !rst;
         assign w_err_evt     = w_bus_err;
      end else begin : g_fsm
         localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

         state_t                r_state;
         logic [3:0]            r_cnt;
         logic [ADDR_WIDTH-1:0] r_idx;
         logic                  r_hit;
         logic [3:0]            r_strb;
         logic [31:0]           r_wdat;
         logic                  r_err;
         logic [31:0]           r_rdata;
         logic                  r_bus_err;

         logic                  w_in_idle;
         logic                  w_to_ready;
         logic [ADDR_WIDTH-1:0] w_acc_idx;
         logic                  w_acc_hit;
         logic [3:0]            w_acc_strb;
         logic [31:0]           w_acc_wdat;
         logic                  w_acc_err;

         assign w_in_idle  = (r_state == S_IDLE);
         // With a single wait state READY is entered straight from IDLE, so
         // the commit uses the live request instead of the latched copy.
         assign w_to_ready = (w_in_idle && ram_en && (WAIT_CYCLES == 1)) ||
                             ((r_state == S_WAIT) && (r_cnt == 4'd1));
         assign w_acc_idx  = w_in_idle ? w_idx          : r_idx;
         assign w_acc_hit  = w_in_idle ? w_hit          : r_hit;
         assign w_acc_strb = w_in_idle ? ram_write_en   : r_strb;
         assign w_acc_wdat = w_in_idle ? ram_write_data : r_wdat;
         assign w_acc_err  = w_in_idle ? w_err          : r_err;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_state   <= S_IDLE;
               r_cnt     <= 4'd0;
               r_idx     <= '0;
               r_hit     <= 1'b0;
               r_strb    <= 4'd0;
               r_wdat    <= 32'h0;
               r_err     <= 1'b0;
               r_rdata   <= 32'h0;
               r_bus_err <= 1'b0;
            end else begin
               r_bus_err <= 1'b0;
               if (w_to_ready) begin
                  // Read-before-write: capture the old word on the commit edge.
                  r_rdata   <= w_acc_hit ? r_mem[w_acc_idx] : 32'h0;
                  r_bus_err <= w_acc_err;
               end
               case (r_state)
                  S_IDLE: begin
                     if (ram_en) begin
                        r_idx   <= w_idx;
                        r_hit   <= w_hit;
                        r_strb  <= ram_write_en;
                        r_wdat  <= ram_write_data;
                        r_err   <= w_err;
                        r_cnt   <= CNT_INIT;
                        r_state <= (WAIT_CYCLES > 1) ? S_WAIT : S_READY;
                     end
                  end
                  S_WAIT: begin
                     r_cnt <= r_cnt - 4'd1;
                     if (r_cnt == 4'd1) r_state <= S_READY;
                  end
                  S_READY: r_state <= S_IDLE;
                  default: r_state <= S_IDLE;
               endcase
            end
         end

         assign stall         = (w_in_idle && ram_en) || (r_state == S_WAIT);
         assign ram_read_data = r_rdata;
         assign w_wr_en       = w_to_ready && w_acc_hit;
         assign w_wr_idx      = w_acc_idx;
         assign w_wr_strb     = w_acc_strb;
         assign w_wr_dat      = w_acc_wdat;
         assign w_bus_err     = r_bus_err;
         assign w_err_evt     = w_to_ready && w_acc_err;
      end
   endgenerate

`ifdef RAM_RESPONDER_ERR_EN
   logic [15:0] r_err_count;
   always_ff @(posedge clk) begin
      if (rst) r_err_count <= 16'h0;
      else if (w_err_evt && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
   end
   assign bus_err   = w_bus_err;
   assign err_count = r_err_count;
`else
   // Error tracking is not built; misses stay silent.
   logic w_unused_err;
   assign w_unused_err = &{1'b0, w_bus_err, w_err_evt, ram_addr[1:0]};
`endif

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

   localparam int          AW   = 10;
   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          WC   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en2 = 1'b0, en0 = 1'b0;
   logic [3:0]  we2 = 4'h0, we0 = 4'h0;
   logic [31:0] addr2 = 32'h0, addr0 = 32'h0, wd2 = 32'h0, wd0 = 32'h0;
   logic [31:0] rd2, rd0;
   logic        st2, st0;
`ifdef RAM_RESPONDER_ERR_EN
   logic        be2, be0;
   logic [15:0] ec2, ec0;
`endif

   ram_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(WC)) u_dut (
      .clk(clk), .rst(rst), .ram_en(en2), .ram_write_en(we2), .ram_addr(addr2),
      .ram_write_data(wd2), .ram_read_data(rd2), .stall(st2)
`ifdef RAM_RESPONDER_ERR_EN
      , .bus_err(be2), .err_count(ec2)
`endif
   );

   ram_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .ram_en(en0), .ram_write_en(we0), .ram_addr(addr0),
      .ram_write_data(wd0), .ram_read_data(rd0), .stall(st0)
`ifdef RAM_RESPONDER_ERR_EN
      , .bus_err(be0), .err_count(ec0)
`endif
   );

   always #5 clk = ~clk;

   int unsigned tick = 0;
   always @(posedge clk) tick <= tick + 1;

   // Reference model: one word map per instance, known words only.
   logic [31:0] m2 [int];
   logic [31:0] m0 [int];
   int          m_ec2 = 0, m_ec0 = 0;
   logic [31:0] last2 = 32'h0;
   int          n_vec = 0, n_err = 0;

   function automatic bit m_hit(input logic [31:0] a);
      return (a >> (AW + 2)) == (BASE >> (AW + 2));
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a >> 2) % (32'd1 << AW));
   endfunction

   function automatic bit m_is_err(input logic [3:0] s, input logic [31:0] a);
      return !m_hit(a) || ((a % 4) != 0 && s == 4'hF);
   endfunction

   function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // One access on the wait-state instance, held like a stalled core.
   task automatic acc2(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] got, output int cyc);
      bit          hit, known, done;
      int          idx, stl;
      logic [31:0] exp;
`ifdef RAM_RESPONDER_ERR_EN
      logic        ge;
      logic [15:0] gc;
      ge = 1'b0;
      gc = 16'h0;
`endif
      hit   = m_hit(a);
      idx   = m_idx(a);
      known = !hit || m2.exists(idx);
      exp   = (hit && known) ? m2[idx] : 32'h0;
      en2 = 1'b1; we2 = s; addr2 = a; wd2 = d;
      cyc = 0; stl = 0; done = 0; got = 32'h0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (st2 === 1'b1) stl++;
         else begin
            done = 1;
            got  = rd2;
`ifdef RAM_RESPONDER_ERR_EN
            ge = be2;
            gc = ec2;
`endif
         end
         @(posedge clk); #1;
      end
      n_vec++;
      if (!done) begin
         n_err++;
         $display("FAIL acc2_timeout addr=%h stall still high after %0d cycles, need %0d", a, cyc, WC + 1);
      end else begin
         if (stl != WC || cyc != WC + 1) begin
            n_err++;
            $display("FAIL acc2_timing addr=%h stall_cycles=%0d total=%0d, need %0d/%0d", a, stl, cyc, WC, WC + 1);
         end
         if (known) begin
            n_vec++;
            if (got !== exp) begin
               n_err++;
               $display("FAIL acc2_data addr=%h got=%h exp=%h", a, got, exp);
            end
         end
`ifdef RAM_RESPONDER_ERR_EN
         if (m_is_err(s, a) && m_ec2 < 65535) m_ec2++;
         n_vec++;
         if (ge !== m_is_err(s, a) || gc !== 16'(m_ec2)) begin
            n_err++;
            $display("FAIL acc2_err addr=%h bus_err=%b cnt=%0d, need %b/%0d", a, ge, gc, m_is_err(s, a), m_ec2);
         end
`endif
      end
      last2 = known ? exp : got;
      if (hit && s != 4'h0 && (m2.exists(idx) || s == 4'hF))
         m2[idx] = m_merge(m2.exists(idx) ? m2[idx] : 32'h0, d, s);
   endtask

   // Idle cycles on the wait-state instance; strobes wiggle but must be ignored.
   task automatic idle2(input int n);
      en2 = 1'b0; we2 = 4'($urandom); addr2 = $urandom; wd2 = $urandom;
      repeat (n) begin
         @(negedge clk);
         n_vec++;
         if (st2 !== 1'b0 || rd2 !== last2) begin
            n_err++;
            $display("FAIL idle2_hold stall=%b rdata=%h, need 0/%h", st2, rd2, last2);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic acc0(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] got);
      bit          hit, known;
      int          idx;
      logic [31:0] exp;
      hit   = m_hit(a);
      idx   = m_idx(a);
      known = !hit || m0.exists(idx);
      exp   = (hit && known) ? m0[idx] : 32'h0;
      en0 = 1'b1; we0 = s; addr0 = a; wd0 = d;
      @(negedge clk);
      got = rd0;
      n_vec++;
      if (st0 !== 1'b0 || (known && got !== exp)) begin
         n_err++;
         $display("FAIL acc0_data addr=%h stall=%b got=%h exp=%h", a, st0, got, exp);
      end
`ifdef RAM_RESPONDER_ERR_EN
      n_vec++;
      if (be0 !== m_is_err(s, a)) begin
         n_err++;
         $display("FAIL acc0_bus_err addr=%h got=%b exp=%b", a, be0, m_is_err(s, a));
      end
      if (m_is_err(s, a) && m_ec0 < 65535) m_ec0++;
`endif
      @(posedge clk); #1;
`ifdef RAM_RESPONDER_ERR_EN
      n_vec++;
      if (ec0 !== 16'(m_ec0)) begin
         n_err++;
         $display("FAIL acc0_err_count got=%0d exp=%0d", ec0, m_ec0);
      end
`endif
      if (hit && s != 4'h0 && (m0.exists(idx) || s == 4'hF))
         m0[idx] = m_merge(m0.exists(idx) ? m0[idx] : 32'h0, d, s);
   endtask

   task automatic idle0(input int n);
      en0 = 1'b0; we0 = 4'($urandom); addr0 = $urandom; wd0 = $urandom;
      repeat (n) begin
         @(negedge clk);
         n_vec++;
         if (st0 !== 1'b0 || rd0 !== 32'h0) begin
            n_err++;
            $display("FAIL idle0 stall=%b rdata=%h, need 0/0", st0, rd0);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (st2 !== 1'b0 || rd2 !== 32'h0 || st0 !== 1'b0 || rd0 !== 32'h0) begin
         n_err++;
         $display("FAIL reset_state st2=%b rd2=%h st0=%b rd0=%h, need all 0", st2, rd2, st0, rd0);
      end
`ifdef RAM_RESPONDER_ERR_EN
      n_vec++;
      if (be2 !== 1'b0 || ec2 !== 16'h0 || ec0 !== 16'h0) begin
         n_err++;
         $display("FAIL reset_err be2=%b ec2=%0d ec0=%0d, need 0", be2, ec2, ec0);
      end
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      last2 = 32'h0;
   endtask

   task automatic test_basic();
      logic [31:0] g;
      int          c;
      acc2(4'hF, 32'h10, 32'hDEADBEEF, g, c);
      idle2(1);
      acc2(4'h0, 32'h10, 32'h0, g, c);
      n_vec++;
      if (g !== 32'hDEADBEEF || c != 3) begin
         n_err++;
         $display("FAIL basic_read got=%h cycles=%0d, need deadbeef/3", g, c);
      end
      idle2(2);
   endtask

   task automatic test_byte_lanes();
      logic [31:0] g;
      int          c;
      acc2(4'hF, 32'h20, 32'h11223344, g, c);
      acc2(4'b0100, 32'h20, 32'h00AA0000, g, c);
      acc2(4'h0, 32'h20, 32'h0, g, c);
      n_vec++;
      if (g !== 32'h11AA3344) begin
         n_err++;
         $display("FAIL byte_lane got=%h exp=11aa3344", g);
      end
      idle2(1);
   endtask

   task automatic test_out_of_range();
      logic [31:0] g;
      int          c;
      acc2(4'hF, 32'h0, 32'hA5A50001, g, c);
      acc2(4'hF, 32'h4, 32'h0B0B0004, g, c);
      idle2(1);
      acc2(4'h0, 32'h0000_1000, 32'h0, g, c);
      n_vec++;
      if (g !== 32'h0 || c != 3) begin
         n_err++;
         $display("FAIL oor_read got=%h cycles=%0d, need 0/3", g, c);
      end
      acc2(4'hF, 32'h0000_1000, 32'hFFFFFFFF, g, c);
      acc2(4'h0, 32'h0, 32'h0, g, c);
      n_vec++;
      if (g !== 32'hA5A50001) begin
         n_err++;
         $display("FAIL oor_alias got=%h exp=a5a50001", g);
      end
      idle2(1);
   endtask

   task automatic test_reset_mid();
      logic [31:0] g;
      int          c;
      acc2(4'hF, 32'h30, 32'h5, g, c);
      idle2(1);
      en2 = 1'b1; we2 = 4'hF; addr2 = 32'h30; wd2 = 32'hCAFEF00D;
      @(posedge clk); #1;
      en2 = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      last2 = 32'h0; m_ec2 = 0; m_ec0 = 0;
      @(negedge clk);
      n_vec++;
      if (st2 !== 1'b0 || rd2 !== 32'h0) begin
         n_err++;
         $display("FAIL reset_mid_state stall=%b rdata=%h, need 0/0", st2, rd2);
      end
      @(posedge clk); #1;
      acc2(4'h0, 32'h30, 32'h0, g, c);
      n_vec++;
      if (g !== 32'h5) begin
         n_err++;
         $display("FAIL reset_mid_abort got=%h exp=00000005", g);
      end
      idle2(1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] g1, g2;
      int          c, t0;
      t0 = int'(tick);
      acc2(4'h0, 32'h0, 32'h0, g1, c);
      acc2(4'h0, 32'h4, 32'h0, g2, c);
      n_vec++;
      if (g1 !== 32'hA5A50001 || g2 !== 32'h0B0B0004 || int'(tick) - t0 != 6) begin
         n_err++;
         $display("FAIL back_to_back d0=%h d1=%h cycles=%0d, need a5a50001/0b0b0004/6", g1, g2, int'(tick) - t0);
      end
      idle2(1);
   endtask

   task automatic test_zero_wait();
      logic [31:0] g;
      acc0(4'hF, 32'h44, 32'h0F0F0F0F, g);
      acc0(4'hF, 32'h44, 32'h12345678, g);
      n_vec++;
      if (g !== 32'h0F0F0F0F) begin
         n_err++;
         $display("FAIL zw_prewrite got=%h exp=0f0f0f0f", g);
      end
      acc0(4'h0, 32'h44, 32'h0, g);
      n_vec++;
      if (g !== 32'h12345678) begin
         n_err++;
         $display("FAIL zw_read got=%h exp=12345678", g);
      end
      idle0(1);
      acc0(4'h0, 32'h2000, 32'h0, g);
      idle0(1);
   endtask

   function automatic logic [31:0] rnd_addr(input logic [31:0] base, input int words);
      logic [31:0] a;
      if ($urandom_range(0, 4) == 0) a = 32'h1000 * (1 + $urandom_range(0, 7)) + 4 * $urandom_range(0, 3);
      else a = base + 4 * $urandom_range(0, words - 1);
      return a + $urandom_range(0, 3);
   endfunction

   function automatic logic [3:0] rnd_strb();
      int r;
      r = $urandom_range(0, 3);
      if (r < 2) return 4'h0;
      if (r == 2) return 4'hF;
      return 4'($urandom_range(1, 15));
   endfunction

   task automatic test_random();
      logic [31:0] g;
      int          c;
      for (int i = 0; i < 16; i++) acc2(4'hF, 32'h100 + 4 * i, $urandom, g, c);
      for (int i = 0; i < 60; i++) begin
         acc2(rnd_strb(), rnd_addr(32'h100, 16), $urandom, g, c);
         if ($urandom_range(0, 2) != 0) idle2($urandom_range(1, 2));
      end
      idle2(1);
      for (int i = 0; i < 8; i++) acc0(4'hF, 32'h200 + 4 * i, $urandom, g);
      for (int i = 0; i < 40; i++) begin
         acc0(rnd_strb(), rnd_addr(32'h200, 8), $urandom, g);
         if ($urandom_range(0, 2) == 0) idle0(1);
      end
      idle0(1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_byte_lanes();
      test_out_of_range();
      test_reset_mid();
      test_back_to_back();
      test_zero_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
